rs232_rx: RTL and testbench
===========================

# rs232_rx

UART receive stage for the serial path. It converts the asynchronous `rx` pin into bytes, framed 8N1 and sent LSB first. It uses 16x oversampling with a 3-sample majority vote at mid-bit. Each good byte is presented with a one-cycle `valid` strobe whose timing matches the `trig` input of `Rs232Tx`, so an echo path is a direct wire-up: `data` to `data`, `valid` to `trig`. Framing errors are reported separately and never strobe `valid`.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115200: line rate.
- `OVERSAMPLE`, default 16: ticks per bit; the design supports only 16.
- `CLK50MHZ` input, 1 bit: single system clock; all logic is on its rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `rx` input, 1 bit: asynchronous serial line; idles high.
- `data` output, 8 bits: last correctly framed byte.
- `valid` output, 1 bit: high for one cycle when `data` is updated.
- `ferr` output, 1 bit: high for one cycle when the stop bit samples low.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Synchronizer**
  - `rx` passes through 2 flops, both reset to 1, giving `rxs`.
  - Everything below uses `rxs` only.
- **Tick generator**
  - `DIV = CLK_HZ/(BAUD*OVERSAMPLE)`, integer-truncated; this is 27 at the defaults.
  - A counter runs 0..DIV-1 and emits `tick` for one cycle when it reaches DIV-1, then wraps to 0.
  - The counter is cleared on entry to START.
- **Sample counter** `s`
  - 4 bits; increments on each `tick` and wraps 15→0.
  - Cleared on entry to START.
  - The ticks that move `s` to 7, 8 and 9 each capture `rxs` into a 3-bit vote register.
  - The bit decision is the majority of those 3 samples, taken on the tick that makes `s`=9.
- **States**: IDLE, START, DATA, STOP.
- **IDLE**
  - Arms only on a 1→0 transition of `rxs`; a line that is merely low does not start a frame.
  - On that transition: go to START and clear both counters.
- **START**
  - At the decision: a majority of 0 goes to DATA with bit index 0.
  - A majority of 1 is a false start: go to IDLE with no output activity.
- **DATA**
  - Each decision shifts into a shift register, LSB first.
  - When `s` wraps after the decision for bit index 7, go to STOP.
- **STOP**, at the decision:
  - Majority 1: load `data` from the shift register and pulse `valid`.
  - Majority 0: pulse `ferr`; `data` is unchanged.
  - Either way, go to IDLE in the same cycle, without waiting for the end of the stop bit. This gives half a bit of margin for back-to-back frames.
- **Break** (line held low): exactly one `ferr`. There is no re-arm until `rxs` has been seen high and then falls again.
- **Reset, including mid-frame**
  - State → IDLE, counters → 0, shift register → 0.
  - Outputs `data`=0x00, `valid`=0, `ferr`=0, `busy`=0.
  - Synchronizer flops → 1, so a low line at reset release does not arm.
  - A partial frame is discarded silently.

## Timing
- `rx` to `rxs`: 2 cycles.
- IDLE→START happens in the cycle after `rxs` first reads 0 with the previous value 1. `busy` rises in that same cycle.
- Decision for bit k (k=0 for start, 1..8 for data, 9 for stop) is on the tick ending `(16k+9)*DIV` cycles after START entry.
- `valid`/`ferr` are registered: high in the cycle after the stop decision (tick 153), i.e. `153*DIV+1` cycles after START entry. That is 4132 at the defaults.
- `busy` falls in the same cycle `valid` or `ferr` rises.
- `valid` and `ferr` are mutually exclusive and are never high in consecutive cycles.
- Divider error at the defaults is 0.5%. The design must tolerate ±3% transmitter baud mismatch.

## Structure
- Shared package `rs232_pkg` holds:
  - the state enum;
  - `OVERSAMPLE`;
  - the `DIV` function of `CLK_HZ`/`BAUD`, shared with `Rs232Tx`;
  - the frame constants `DATA_BITS`=8 and `STOP_BITS`=1.
- One sub-module, `baud_tick_gen`, contains the divider with a synchronous clear and the `tick` output. It is reusable by the transmitter.

## Test plan
- **Single byte**: drive 0x66 ('f') at exactly 115200 → `data`=0x66, `valid` high for 1 cycle at `153*27+1` cycles after START entry, `ferr`=0.
- **Back-to-back**: 0x55 then 0xAA with one stop bit and no idle gap → two `valid` pulses, `data`=0x55 then 0xAA, no `ferr`.
- **Glitch and noise**
  - A low pulse of 4 ticks (108 cycles) on an idle line → false start: no `valid`, no `ferr`, `busy` back to 0.
  - A one-tick high spike centred on a data bit of 0x00 → majority vote still yields 0x00.
- **Framing**
  - 0x3C sent with a low stop bit → `ferr` pulses 1 cycle, `data` keeps its previous value, no `valid`.
  - Line held low for 20 bit times → exactly one `ferr`.
  - Line then released high and 0x41 sent → `data`=0x41.
- **Reset mid-frame**: assert `RST` for 1 cycle during data bit 3 of 0x7E → outputs at reset values next cycle, no `valid` for that frame; the next frame 0x81 is received correctly.
- **Baud skew**: 0xA5 sent at +3% and then at −3% of 115200 → both received as 0xA5 with `valid`.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 serial path: FSM states, frame constants,
// the baud divider function and the majority-vote helper.
package rs232_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;

  // Clock cycles per oversample tick, truncated.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle registered tick every DIV cycles,
// with a synchronous clear that restarts the count phase.
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_r;
  logic         tick_r;

  // Divider counter and tick register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + ONE;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling, 3-sample majority
// vote at mid-bit, one-cycle valid/ferr strobes.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);

  logic       sync1_r;
  logic       rxs_r;
  logic       rxs_prev_r;
  rx_state_e  state_r;
  logic [3:0] s_r;
  logic [1:0] vote_r;
  logic [3:0] bit_idx_r;
  logic [7:0] shift_r;
  logic [7:0] data_r;
  logic       valid_r;
  logic       ferr_r;
  logic       busy_r;

  logic       tick_s;
  logic       fall_s;
  logic       clr_s;
  logic [3:0] s_next_s;
  logic       vote_tick_s;
  logic       decide_s;
  logic       bit_s;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (CLK50MHZ),
    .rst  (RST),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Two-stage synchronizer plus previous-value flop for falling-edge detect.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      rxs_prev_r <= 1'b1;
    end else begin
      sync1_r    <= rx;
      rxs_r      <= sync1_r;
      rxs_prev_r <= rxs_r;
    end
  end

  // The third vote sample is the live rxs on the deciding tick, so only the
  // two earlier samples need storage.
  always_comb begin
    fall_s      = rxs_prev_r & ~rxs_r;
    clr_s       = (state_r == IDLE) && fall_s;
    s_next_s    = s_r + 4'd1;
    vote_tick_s = tick_s && ((s_next_s == 4'd7) || (s_next_s == 4'd8) || (s_next_s == 4'd9));
    decide_s    = tick_s && (s_next_s == 4'd9);
    bit_s       = maj3({vote_r, rxs_r});
  end

  // Frame FSM with sample counter, vote register, shifter and registered outputs.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_r   <= IDLE;
      s_r       <= 4'd0;
      vote_r    <= 2'b00;
      bit_idx_r <= 4'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;

      if (clr_s) begin
        s_r    <= 4'd0;
        vote_r <= 2'b00;
      end else if (tick_s) begin
        s_r <= s_next_s;
        if (vote_tick_s) begin
          vote_r <= {vote_r[0], rxs_r};
        end
      end

      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (decide_s) begin
            if (bit_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= DATA;
              bit_idx_r <= 4'd0;
            end
          end
        end
        DATA: begin
          if (decide_s) begin
            shift_r   <= {bit_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 4'd1;
          end else if (tick_s && (s_r == 4'd15) && (bit_idx_r == 4'(DATA_BITS))) begin
            state_r <= STOP;
          end
        end
        STOP: begin
          // Return to IDLE at mid-stop to leave margin for back-to-back frames.
          if (decide_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (bit_s) begin
              data_r  <= shift_r;
              valid_r <= 1'b1;
            end else begin
              ferr_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data  = data_r;
  assign valid = valid_r;
  assign ferr  = ferr_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx: a frame-level expectation queue predicts
// valid/ferr/busy/data for every cycle, plus literal pins on the model.
module tb_rs232_rx;

  localparam int D       = 27;
  localparam int BIT     = 434;            // 50 MHz / 115200, rounded
  localparam int BIT_FST = 421;            // +3% baud
  localparam int BIT_SLW = 447;            // -3% baud
  localparam int GOOD = 0, FERR = 1, FALSE_START = 2;

  typedef struct {
    int         t0;
    int         tend;
    int         kind;
    logic [7:0] b;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int reset_at = -1;
  int first_valid_cyc = -1;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  bit chk_en = 1'b0;

  frame_t     q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid, exp_ferr, exp_busy;

  rs232_rx dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ferr     (ferr),
    .busy     (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // A line change made in cycle c reaches rxs in c+2, so START is entered in c+3;
  // the outcome lands 153*DIV+1 cycles later, a false start leaves after 9*DIV+1.
  task automatic expect_frame(input int kind, input logic [7:0] b);
    frame_t f;
    f.t0   = cyc + 3;
    f.tend = (kind == FALSE_START) ? f.t0 + 9 * D + 1 : f.t0 + 153 * D + 1;
    f.kind = kind;
    f.b    = b;
    q.push_back(f);
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bitlen, input logic stop_v, input int kind);
    expect_frame(kind, b);
    hold(1'b0, bitlen);
    for (int i = 0; i < 8; i++) hold(b[i], bitlen);
    hold(stop_v, bitlen);
  endtask

  // Per-cycle comparison against the frame-level expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == reset_at) begin
        q.delete();
        exp_data = 8'h00;
      end
      while (q.size() > 0 && q[0].tend < cyc) void'(q.pop_front());
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_busy  = 1'b0;
      foreach (q[i]) begin
        if (cyc >= q[i].t0 && cyc < q[i].tend) exp_busy = 1'b1;
        if (cyc == q[i].tend && q[i].kind == GOOD) begin
          exp_valid = 1'b1;
          exp_data  = q[i].b;
        end
        if (cyc == q[i].tend && q[i].kind == FERR) exp_ferr = 1'b1;
      end
      check("valid", 32'(valid), 32'(exp_valid));
      check("ferr",  32'(ferr),  32'(exp_ferr));
      check("busy",  32'(busy),  32'(exp_busy));
      check("data",  32'(data),  32'(exp_data));
      if (valid === 1'b1) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (ferr === 1'b1) ferr_cnt++;
    end
  end

  initial begin
    int f0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    hold(1'b1, 200);

    // Single byte at nominal rate.
    f0 = cyc;
    send_frame(8'h66, BIT, 1'b1, GOOD);
    hold(1'b1, 500);
    check("latency_0x66", 32'(first_valid_cyc - f0), 32'd4135);
    check("data_0x66", 32'(data), 32'h66);

    // Four-tick low glitch on an idle line.
    expect_frame(FALSE_START, 8'h00);
    hold(1'b0, 108);
    hold(1'b1, 700);

    // 0x00 with a one-tick high spike centred on the middle sample of data bit 2.
    expect_frame(GOOD, 8'h00);
    hold(1'b0, BIT * 3);
    hold(1'b0, 198);
    hold(1'b1, 27);
    hold(1'b0, 209);
    hold(1'b0, BIT * 5);
    hold(1'b1, BIT);
    hold(1'b1, 500);
    check("data_spike", 32'(data), 32'h00);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, BIT, 1'b1, GOOD);
    send_frame(8'hAA, BIT, 1'b1, GOOD);
    hold(1'b1, 500);

    // Low stop bit: ferr only, data keeps 0xAA.
    send_frame(8'h3C, BIT, 1'b0, FERR);
    hold(1'b1, 500);
    check("data_after_ferr", 32'(data), 32'hAA);

    // Break: line low for 20 bit times gives a single ferr.
    expect_frame(FERR, 8'h00);
    hold(1'b0, BIT * 20);
    hold(1'b1, 500);
    send_frame(8'h41, BIT, 1'b1, GOOD);
    hold(1'b1, 500);
    check("data_0x41", 32'(data), 32'h41);

    // Reset during data bit 3 of 0x7E; the sender is reset with the receiver.
    expect_frame(GOOD, 8'h7E);
    hold(1'b0, BIT);
    hold(1'b0, BIT);
    hold(1'b1, BIT * 2);
    hold(1'b1, 200);
    rst = 1'b1;
    reset_at = cyc + 1;
    hold(1'b1, 1);
    rst = 1'b0;
    check("data_reset", 32'(data), 32'h00);
    check("busy_reset", 32'(busy), 32'h0);
    hold(1'b1, 500);
    send_frame(8'h81, BIT, 1'b1, GOOD);
    hold(1'b1, 500);
    check("data_0x81", 32'(data), 32'h81);

    // Baud skew of +3% and -3%.
    send_frame(8'hA5, BIT_FST, 1'b1, GOOD);
    hold(1'b1, 500);
    send_frame(8'hA5, BIT_SLW, 1'b1, GOOD);
    hold(1'b1, 500);
    check("data_skew", 32'(data), 32'hA5);

    check("valid_count", 32'(valid_cnt), 32'd8);
    check("ferr_count", 32'(ferr_cnt), 32'd2);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
